// File: rtl/lpc_tpm_responder_if.sv
// LPC target-side bus bundle: LAD/LFRAME# from the host plus the register-side
// strobe interface.
//   master : host / register model side (drives frame, inAd, rdValid, rdData)
//   slave  : lpc_tpm_responder side (drives outAd, enable, addr, wrData,
//            wrStrobe, rdReq)
interface lpc_tpm_responder_if;
  logic        frame;     // LFRAME#, active low
  logic [3:0]  inAd;      // LAD as sampled from the IOBUF
  logic [3:0]  outAd;     // LAD drive value
  logic        enable;    // LAD output enable
  logic [15:0] addr;      // latched cycle address
  logic [7:0]  wrData;    // latched write byte
  logic        wrStrobe;  // claimed write completed
  logic        rdReq;     // claimed read needs data
  logic        rdValid;   // read data available
  logic [7:0]  rdData;    // read byte

  modport master (
    output frame, inAd, rdValid, rdData,
    input  outAd, enable, addr, wrData, wrStrobe, rdReq
  );

  modport slave (
    input  frame, inAd, rdValid, rdData,
    output outAd, enable, addr, wrData, wrStrobe, rdReq
  );
endinterface

// File: rtl/lpc_tpm_responder.sv
// LPC I/O-cycle target: decodes START/CYCTYP/address/data nibbles from LAD,
// answers claimed I/O reads and writes with SYNC, data and turn-around, and
// exposes a strobe interface for a register model behind it.
// Ports:
//   clk   : bus clock, all logic on posedge
//   reset : asynchronous, active-high
//   bus   : lpc_tpm_responder_if.slave (LAD/LFRAME# + register strobes)
module lpc_tpm_responder #(
  parameter logic [3:0]  START_CODE = 4'b0101,
  parameter logic [15:0] ADDR_BASE  = 16'h0000,
  parameter logic [15:0] ADDR_MASK  = 16'hFF00,
  parameter int unsigned WR_WAIT    = 2,
  parameter logic [7:0]  MAX_WAIT   = 8'd32
) (
  input  logic               clk,
  input  logic               reset,
  lpc_tpm_responder_if.slave bus
);

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;
  localparam logic [3:0] TAR_NIB    = 4'b1111;
  localparam logic [7:0] WR_WAIT_C  = 8'(WR_WAIT);

  typedef enum logic [3:0] {
    IDLE, CYCTYP, ADDR, WDATA, HTAR1, HTAR2, SYNC, RDATA, PTAR1, PTAR2, IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic        is_write, is_write_nxt;
  logic [1:0]  nib, nib_nxt;
  logic [11:0] addr_sh, addr_sh_nxt;
  logic [3:0]  wr_lo, wr_lo_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        have_data, have_nxt;
  logic [7:0]  rd_buf, rd_buf_nxt;
  logic [3:0]  lad_drv, lad_drv_nxt;
  logic        lad_en, lad_en_nxt;
  logic [15:0] cyc_addr, cyc_addr_nxt;
  logic [7:0]  wr_byte, wr_byte_nxt;
  logic        wr_pulse, wr_pulse_nxt;
  logic        rd_pulse, rd_pulse_nxt;

  logic [15:0] full_addr;
  logic [7:0]  wait_inc;
  logic        capture;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      nib       <= 2'd0;
      addr_sh   <= 12'd0;
      wr_lo     <= 4'd0;
      wait_cnt  <= 8'd0;
      have_data <= 1'b0;
      rd_buf    <= 8'd0;
      lad_drv   <= 4'h0;
      lad_en    <= 1'b0;
      cyc_addr  <= 16'd0;
      wr_byte   <= 8'd0;
      wr_pulse  <= 1'b0;
      rd_pulse  <= 1'b0;
    end else begin
      state     <= state_nxt;
      is_write  <= is_write_nxt;
      nib       <= nib_nxt;
      addr_sh   <= addr_sh_nxt;
      wr_lo     <= wr_lo_nxt;
      wait_cnt  <= wait_nxt;
      have_data <= have_nxt;
      rd_buf    <= rd_buf_nxt;
      lad_drv   <= lad_drv_nxt;
      lad_en    <= lad_en_nxt;
      cyc_addr  <= cyc_addr_nxt;
      wr_byte   <= wr_byte_nxt;
      wr_pulse  <= wr_pulse_nxt;
      rd_pulse  <= rd_pulse_nxt;
    end
  end

  // Next state; LAD value/enable are computed for the cycle being entered
  always_comb begin
    state_nxt    = state;
    is_write_nxt = is_write;
    nib_nxt      = nib;
    addr_sh_nxt  = addr_sh;
    wr_lo_nxt    = wr_lo;
    wait_nxt     = wait_cnt;
    have_nxt     = have_data;
    rd_buf_nxt   = rd_buf;
    lad_drv_nxt  = 4'h0;
    lad_en_nxt   = 1'b0;
    cyc_addr_nxt = cyc_addr;
    wr_byte_nxt  = wr_byte;
    wr_pulse_nxt = 1'b0;
    rd_pulse_nxt = 1'b0;

    full_addr = {addr_sh, bus.inAd};
    wait_inc  = wait_cnt + 8'd1;
    // Only the first rdValid of a claimed read is taken
    capture   = !is_write && !have_data && bus.rdValid;

    if (!bus.frame) begin
      // Frame low is always a START check; in-flight cycles are abandoned
      state_nxt = (bus.inAd == START_CODE) ? CYCTYP : IDLE;
    end else begin
      case (state)
        IDLE, IGNORE: state_nxt = state;
        CYCTYP: begin
          nib_nxt = 2'd0;
          if (bus.inAd == 4'b0000) begin
            is_write_nxt = 1'b0;
            state_nxt    = ADDR;
          end else if (bus.inAd == 4'b0010) begin
            is_write_nxt = 1'b1;
            state_nxt    = ADDR;
          end else begin
            state_nxt = IGNORE;
          end
        end
        ADDR: begin
          addr_sh_nxt = full_addr[11:0];
          nib_nxt     = nib + 2'd1;
          if (nib == 2'd3) begin
            nib_nxt = 2'd0;
            if ((full_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK)) begin
              cyc_addr_nxt = full_addr;
              have_nxt     = 1'b0;
              if (is_write) begin
                state_nxt = WDATA;
              end else begin
                state_nxt    = HTAR1;
                rd_pulse_nxt = 1'b1;
              end
            end else begin
              state_nxt = IGNORE;
            end
          end
        end
        WDATA: begin
          if (nib == 2'd0) begin
            wr_lo_nxt = bus.inAd;
            nib_nxt   = 2'd1;
          end else begin
            wr_byte_nxt = {bus.inAd, wr_lo};
            nib_nxt     = 2'd0;
            state_nxt   = HTAR1;
          end
        end
        HTAR1: begin
          state_nxt = HTAR2;
          if (capture) begin
            have_nxt   = 1'b1;
            rd_buf_nxt = bus.rdData;
          end
        end
        HTAR2: begin
          state_nxt  = SYNC;
          lad_en_nxt = 1'b1;
          wait_nxt   = 8'd0;
          if (is_write) begin
            lad_drv_nxt  = (WR_WAIT_C == 8'd0) ? SYNC_READY : SYNC_SHORT;
            wr_pulse_nxt = (WR_WAIT_C == 8'd0);
          end else if (have_data || capture) begin
            lad_drv_nxt = SYNC_READY;
            if (capture) begin
              have_nxt   = 1'b1;
              rd_buf_nxt = bus.rdData;
            end
          end else begin
            lad_drv_nxt = SYNC_SHORT;
          end
        end
        SYNC: begin
          lad_en_nxt = 1'b1;
          if (lad_drv == SYNC_SHORT) begin
            wait_nxt = wait_inc;
            if (is_write) begin
              lad_drv_nxt  = (wait_inc >= WR_WAIT_C) ? SYNC_READY : SYNC_SHORT;
              wr_pulse_nxt = (wait_inc >= WR_WAIT_C);
            end else if (capture) begin
              have_nxt    = 1'b1;
              rd_buf_nxt  = bus.rdData;
              lad_drv_nxt = SYNC_READY;
            end else if (wait_inc >= MAX_WAIT) begin
              // Error SYNC: the data phase then returns all ones
              rd_buf_nxt  = 8'hFF;
              lad_drv_nxt = SYNC_ERR;
            end else begin
              lad_drv_nxt = SYNC_SHORT;
            end
          end else if (is_write) begin
            state_nxt   = PTAR1;
            lad_drv_nxt = TAR_NIB;
          end else begin
            state_nxt   = RDATA;
            nib_nxt     = 2'd0;
            lad_drv_nxt = rd_buf[3:0];
          end
        end
        RDATA: begin
          lad_en_nxt = 1'b1;
          if (nib == 2'd0) begin
            nib_nxt     = 2'd1;
            lad_drv_nxt = rd_buf[7:4];
          end else begin
            nib_nxt     = 2'd0;
            state_nxt   = PTAR1;
            lad_drv_nxt = TAR_NIB;
          end
        end
        PTAR1:   state_nxt = PTAR2;
        PTAR2:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.outAd    = lad_drv;
  assign bus.enable   = lad_en;
  assign bus.addr     = cyc_addr;
  assign bus.wrData   = wr_byte;
  assign bus.wrStrobe = wr_pulse;
  assign bus.rdReq    = rd_pulse;

endmodule

// File: tb/tb_lpc_tpm_responder.sv
// Bench for lpc_tpm_responder: transactions push the expected bus events
// (driven LAD nibbles, wrStrobe, rdReq) with their cycle numbers into a queue;
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_lpc_tpm_responder;
  localparam int unsigned WR_W  = 2;
  localparam int unsigned MAX_W = 4;
  localparam logic [3:0]  START = 4'b0101;
  localparam logic [15:0] BASE  = 16'h0000;
  localparam logic [15:0] MASK  = 16'hFF00;

  // kind: 0 = driven LAD nibble, 1 = wrStrobe, 2 = rdReq
  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  ev_t  exp_q[$];
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  lpc_tpm_responder_if bus();

  lpc_tpm_responder #(
    .START_CODE(START), .ADDR_BASE(BASE), .ADDR_MASK(MASK),
    .WR_WAIT(WR_W), .MAX_WAIT(8'(MAX_W))
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL bus_event: got kind=%0d cyc=%0d a=%h d=%h required no activity", kind, cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a !== a || e.d !== d) begin
        errors++;
        $display("FAIL bus_event: got kind=%0d cyc=%0d a=%h d=%h required kind=%0d cyc=%0d a=%h d=%h",
                 kind, cyc, a, d, e.kind, e.cyc, e.a, e.d);
      end
    end
  endtask

  // Monitor: same-cycle order is strobe, request, then LAD nibble
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.wrStrobe) expect_ev(1, bus.addr, bus.wrData);
      if (bus.rdReq)    expect_ev(2, bus.addr, 8'h00);
      if (bus.enable)   expect_ev(0, 16'h0000, {4'h0, bus.outAd});
    end
  end

  function automatic void push(input int c, input int kind, input logic [15:0] a,
                               input logic [7:0] d, input int lim);
    if (c <= lim) exp_q.push_back('{c, kind, a, d});
  endfunction

  // One host cycle. d = rdValid delay after the rdReq cycle (-1: never);
  // cut > 0 stops after that many cycles (frame abort by the next START,
  // or asynchronous reset when cut_rst is set).
  task automatic run_txn(input logic [3:0] pre, input bit two_start, input logic [3:0] start,
                         input logic [3:0] cyctyp, input logic [15:0] a, input logic [7:0] wd,
                         input int d, input bit level, input logic [7:0] rd,
                         input int cut, input bit cut_rst, input bit junk, input int gap);
    int   t0, s, w, len, lim, base;
    bit   claimed, wr, err, rv, cutting;
    logic [3:0] nb;
    logic [7:0] rdat;
    wr      = (cyctyp == 4'b0010);
    claimed = (start == START) && (cyctyp == 4'b0000 || wr) && ((a & MASK) == (BASE & MASK));
    err     = 1'b0;
    if (wr) begin
      w = WR_W;  s = WR_W + 1;
    end else if (d >= 0 && d <= 1) begin
      w = 0;     s = 1;
    end else if (d >= 2 && d < int'(MAX_W) + 2) begin
      w = d - 1; s = d;
    end else begin
      err = 1'b1; w = MAX_W; s = MAX_W + 1;
    end
    len     = claimed ? 12 + s : 8;
    cutting = (cut > 0 && cut < len);

    if (two_start) begin
      bus.frame = 1'b0; bus.inAd = pre; bus.rdValid = 1'b0;
      next_cycle();
    end
    t0  = cyc;
    lim = cutting ? (cut_rst ? t0 + cut - 1 : t0 + cut) : t0 + 100000;

    if (claimed && wr) begin
      base = t0 + 10;
      for (int i = 0; i < w; i++) push(base + i, 0, 16'h0, 8'h05, lim);
      push(base + w, 1, a, wd, lim);
      push(base + w, 0, 16'h0, 8'h00, lim);
      push(base + w + 1, 0, 16'h0, 8'h0F, lim);
    end else if (claimed) begin
      push(t0 + 6, 2, a, 8'h00, lim);
      base = t0 + 8;
      for (int i = 0; i < w; i++) push(base + i, 0, 16'h0, 8'h05, lim);
      if (err) begin
        push(base + w, 0, 16'h0, 8'h0A, lim);
        push(base + w + 1, 0, 16'h0, 8'h0F, lim);
        push(base + w + 2, 0, 16'h0, 8'h0F, lim);
      end else begin
        push(base + w, 0, 16'h0, 8'h00, lim);
        push(base + w + 1, 0, 16'h0, {4'h0, rd[3:0]}, lim);
        push(base + w + 2, 0, 16'h0, {4'h0, rd[7:4]}, lim);
      end
      push(base + w + 3, 0, 16'h0, 8'h0F, lim);
    end

    for (int o = 0; o < len; o++) begin
      if (cutting && o == cut) break;
      case (o)
        0:       nb = start;
        1:       nb = cyctyp;
        2:       nb = a[15:12];
        3:       nb = a[11:8];
        4:       nb = a[7:4];
        5:       nb = a[3:0];
        6:       nb = wr ? wd[3:0] : 4'hF;
        7:       nb = wr ? wd[7:4] : 4'hF;
        default: nb = 4'hF;
      endcase
      rv   = !wr && d >= 0 && (level ? (o >= 6 + d) : (o == 6 + d));
      rdat = (!wr && d >= 0 && o == 6 + d) ? rd : 8'($urandom);
      if (junk && (o == 3 || (wr && o == 8))) rv = 1'b1;
      bus.frame   = (o == 0) ? 1'b0 : 1'b1;
      bus.inAd    = nb;
      bus.rdValid = rv;
      bus.rdData  = rdat;
      next_cycle();
    end

    if (cutting && cut_rst) begin
      bus.frame = 1'b1; bus.inAd = 4'hF; bus.rdValid = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("async_rst_enable", {15'h0, bus.enable}, 16'h0000);
      chk("async_rst_outAd", {12'h0, bus.outAd}, 16'h0000);
      chk("async_rst_addr", bus.addr, 16'h0000);
      chk("async_rst_wrData", {8'h0, bus.wrData}, 16'h0000);
      chk("async_rst_strobes", {14'h0, bus.wrStrobe, bus.rdReq}, 16'h0000);
      next_cycle();
      next_cycle();
      reset = 1'b0;
    end else if (!cutting) begin
      for (int g = 0; g < gap; g++) begin
        bus.frame = 1'b1; bus.inAd = 4'hF; bus.rdValid = 1'b0;
        next_cycle();
      end
    end
  endtask

  initial begin
    logic [3:0]  r_ct;
    logic [15:0] r_a;
    int          r_d, r_cut;
    reset = 1'b1;
    bus.frame = 1'b1; bus.inAd = 4'hF; bus.rdValid = 1'b0; bus.rdData = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outAd", {12'h0, bus.outAd}, 16'h0000);
    chk("reset_enable", {15'h0, bus.enable}, 16'h0000);
    chk("reset_addr", bus.addr, 16'h0000);
    chk("reset_wrData", {8'h0, bus.wrData}, 16'h0000);
    chk("reset_wrStrobe", {15'h0, bus.wrStrobe}, 16'h0000);
    chk("reset_rdReq", {15'h0, bus.rdReq}, 16'h0000);
    reset = 1'b0;
    next_cycle();

    // Write with two short waits, then back-to-back zero-wait read
    run_txn(4'h0, 0, START, 4'b0010, 16'h0024, 8'hA5, -1, 0, 8'h00, 0, 0, 0, 0);
    run_txn(4'h0, 0, START, 4'b0000, 16'h0018, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 1);
    // rdValid five cycles after rdReq, held as a level
    run_txn(4'h0, 0, START, 4'b0000, 16'h0042, 8'h00, 5, 1, 8'h96, 0, 0, 1, 0);
    // rdValid never arrives: error SYNC
    run_txn(4'h0, 0, START, 4'b0000, 16'h0010, 8'h00, -1, 0, 8'h00, 0, 0, 0, 0);
    // Decode miss and unsupported CYCTYP, each followed immediately by a good cycle
    run_txn(4'h0, 0, START, 4'b0010, 16'h1000, 8'h11, -1, 0, 8'h00, 0, 0, 0, 0);
    run_txn(4'h0, 0, START, 4'b0000, 16'h0007, 8'h00, 1, 0, 8'h5A, 0, 0, 0, 0);
    run_txn(4'h0, 0, START, 4'b0100, 16'h0003, 8'h00, -1, 0, 8'h00, 0, 0, 0, 0);
    run_txn(4'h3, 1, START, 4'b0010, 16'h00FF, 8'hC3, -1, 0, 8'h00, 0, 0, 0, 2);
    // Abort during WDATA by a new read START
    run_txn(4'h0, 0, START, 4'b0010, 16'h0055, 8'h77, -1, 0, 8'h00, 7, 0, 0, 0);
    run_txn(4'h0, 0, START, 4'b0000, 16'h0020, 8'h00, 3, 0, 8'hE1, 0, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:          r_ct = 4'($urandom);
        1, 2, 3, 4: r_ct = 4'b0000;
        default:    r_ct = 4'b0010;
      endcase
      r_a   = ($urandom_range(0, 6) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      r_d   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8));
      r_cut = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 14)) : 0;
      run_txn(4'($urandom), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 9) == 0) ? 4'($urandom) : START,
              r_ct, r_a, 8'($urandom), r_d, 1'($urandom), 8'($urandom),
              r_cut, 0, 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset during the SYNC phase of a read, then a normal write
    run_txn(4'h0, 0, START, 4'b0000, 16'h0030, 8'h00, -1, 0, 8'h00, 9, 1, 0, 0);
    run_txn(4'h0, 0, START, 4'b0010, 16'h0001, 8'h7E, -1, 0, 8'h00, 0, 0, 0, 2);

    repeat (20) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding (first at cyc %0d) required 0",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lpc_tpm_responder.md
# lpc_tpm_responder

Peripheral (target) end of the LPC bus driven by the FPGA's LPC host: decodes START/CYCTYP/address/data nibbles on the shared LAD lines and answers I/O read and write cycles with SYNC, data and turn-around. It presents a simple register-side strobe interface, so a TPM register model or a loopback memory can sit behind it. This lets the host controller and the TPM command path run in simulation and on the board without a physical TPM attached.

## Interface
- START_CODE, 4'b0101: LAD START nibble accepted (TPM cycle); any other START is ignored.
- ADDR_BASE, 16'h0000: decode base address.
- ADDR_MASK, 16'hFF00: decode mask; a cycle is claimed iff (addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK).
- WR_WAIT, 2: short-wait SYNC cycles inserted before the ready SYNC on writes (0..15).
- MAX_WAIT, 8'd32: maximum short-wait SYNCs on reads before the error SYNC.
- clk  in  1  bus/system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- frame  in  1  LFRAME#, active low.
- inAd  in  4  LAD sampled from the IOBUF.
- outAd  out  4  LAD drive value.
- enable  out  1  LAD output enable (IOBUF T = ~enable).
- addr  out  16  latched cycle address; valid from rdReq/wrStrobe until the next claimed cycle.
- wrData  out  8  latched write byte.
- wrStrobe  out  1  one-cycle pulse: claimed write completed.
- rdReq  out  1  one-cycle pulse: claimed read needs data.
- rdValid  in  1  read data available (level or pulse; first high cycle after rdReq captured).
- rdData  in  8  read byte, sampled when rdValid is high.

## Operation
- States: IDLE, CYCTYP, ADDR (4 nibbles, MSB first), WDATA (2 nibbles, low first), HTAR1, HTAR2, SYNC, RDATA (2 nibbles, low first), PTAR1, PTAR2, IGNORE.
- IDLE: when frame==0 and inAd==START_CODE, arm. While frame stays low, re-evaluate START every cycle (the last START wins). The first cycle with frame==1 after arming is CYCTYP.
- CYCTYP: inAd==4'b0000 means I/O read; 4'b0010 means I/O write; anything else goes to IGNORE.
- ADDR: shift 4 nibbles into the address. After the 4th nibble, apply decode. A miss goes to IGNORE: no strobes, and the bus is never driven.
- Write path: ADDR, then WDATA (wrData[3:0] first, then [7:4]), then HTAR1, HTAR2, then SYNC.
  - In SYNC, drive 4'b0101 for WR_WAIT cycles, then 4'b0000 for one cycle.
  - wrStrobe pulses in the same cycle the 4'b0000 SYNC is driven.
  - Then PTAR1 drives 4'b1111, then PTAR2 releases the bus, then IDLE.
- Read path: rdReq pulses in the HTAR1 cycle, then HTAR2, then SYNC.
  - In SYNC, drive 4'b0101 until data is captured, then drive 4'b0000 for one cycle.
  - After the 0000 SYNC: RDATA drives rdData[3:0], then rdData[7:4], then PTAR1 (1111), then PTAR2, then IDLE.
- Wait counter: 8-bit, cleared on entering SYNC, incremented per 0101 SYNC cycle.
  - If it reaches MAX_WAIT with no capture, drive 4'b1010 (error SYNC) for one cycle.
  - Then RDATA drives 4'hF, 4'hF, then PTAR.
- Data capture register: rdValid seen in HTAR1/HTAR2 is captured, and the first SYNC is then 0000 (zero-wait read). Capture is ignored outside a claimed read.
- IGNORE: stay off the bus until frame==0, then handle it exactly as IDLE (START check in the same cycle).
- Abort: frame==0 in any state other than IDLE/IGNORE aborts the cycle.
  - enable drops on the next edge and no further strobes occur.
  - That frame-low cycle is treated as an IDLE START check.
  - A wrStrobe already issued is not retracted.

## Timing
- outAd and enable are registered. The value for a bus cycle is set on the edge entering that state, so it is stable for the whole cycle.
- enable is 1 only in SYNC, RDATA and PTAR1; it is 0 in PTAR2 and all other states.
- Zero-wait write (WR_WAIT=0): frame-low START cycle, then 1 CYCTYP + 4 ADDR + 2 WDATA + 2 HTAR + 1 SYNC + 2 PTAR = 12 cycles after START.
- Zero-wait read: 1 CYCTYP + 4 ADDR + 2 HTAR + 1 SYNC + 2 RDATA + 2 PTAR = 12 cycles after START.
- Reset values: outAd=4'h0, enable=0, addr=0, wrData=0, wrStrobe=0, rdReq=0, state=IDLE, wait counter=0, capture flag=0.
- Reset asserted mid-cycle releases the bus (enable=0) immediately and asynchronously.
- Back-to-back: a START in the cycle after PTAR2 must be accepted.

## Test plan
- I/O write, START=0101, addr 16'h0024, data 8'hA5, WR_WAIT=2 -> SYNC sequence 0101,0101,0000; wrStrobe on the 0000 cycle with addr=16'h0024, wrData=8'hA5; PTAR 1111, then release.
- I/O read, addr 16'h0018, rdValid=1 with rdData=8'h3C during HTAR1 -> SYNC 0000 immediately; LAD 4'hC then 4'h3; enable low in PTAR2.
- I/O read with rdValid delayed 5 cycles after rdReq -> at least 3 SYNC 0101 cycles, then 0000, then data; rdReq pulses exactly once.
- Read with MAX_WAIT=4 and rdValid never asserted -> 4×0101, then 1010, then FF data nibbles, then PTAR; back in IDLE.
- Address 16'h1000 with default decode, and a CYCTYP of 4'b0100 -> enable never asserted and no strobes; the next valid cycle immediately after is answered normally.
- Abort: frame driven low during WDATA, followed by a new read START -> no wrStrobe, and the new read completes. Reset asserted during SYNC -> enable=0 within the same cycle and all outputs at their reset values.
